// File: rtl/tank_motion.sv
// Grid-locked tank motion controller. Samples the keycode once per video
// frame, claims the neighbouring 32x32 cell when it is free, and slides
// into it STEP pixels per frame. Two instances are cross-connected; the
// YIELD=1 instance evaluates one Clk late and therefore loses ties.
module tank_motion #(
    parameter logic [9:0] START_X = 10'd0,
    parameter logic [9:0] START_Y = 10'd0,
    parameter int         STEP    = 2,
    parameter int         YIELD   = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] OtherX,
    input  logic [9:0] OtherY,
    input  logic [4:0] OtherTgtCol,
    input  logic [4:0] OtherTgtRow,
    output logic [9:0] TankX,
    output logic [9:0] TankY,
    output logic [4:0] TgtCol,
    output logic [4:0] TgtRow,
    output logic [1:0] Dir,
    output logic       Moving
);

    localparam logic [9:0] STEP_V   = 10'(STEP);
    localparam logic [4:0] LAST_COL = 5'd19;
    localparam logic [4:0] LAST_ROW = 5'd14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    // Cell index of a pixel coordinate (floor division by 32).
    function automatic logic [4:0] cell_of(input logic [9:0] pix);
        return pix[9:5];
    endfunction

    state_t     state_r, state_n;
    logic [9:0] x_r, y_r, x_n, y_n;
    logic [4:0] tcol_r, trow_r, tcol_n, trow_n;
    logic [1:0] dir_r, dir_n;
    logic       moving_r;

    logic       sync1_r, sync2_r, sync3_r, tick_r;
    logic       etick_s;

    logic       key_valid_s;
    logic [1:0] key_dir_s;
    logic [4:0] cur_col_s, cur_row_s, cand_col_s, cand_row_s;
    logic       off_grid_s, blocked_s;
    logic [1:0] move_dir_s;
    logic [4:0] dest_col_s, dest_row_s;
    logic [9:0] step_x_s, step_y_s;
    logic       arrive_s;

    // Two-flop synchronizer for frame_clk plus registered rising-edge pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            sync1_r <= frame_clk;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            tick_r  <= sync2_r & ~sync3_r;
        end
    end

    generate
        if (YIELD != 0) begin : g_yield
            logic etick_r;
            // Delay the frame tick by one Clk so the peer's fresh claim is visible.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    etick_r <= 1'b0;
                end else begin
                    etick_r <= tick_r;
                end
            end
            assign etick_s = etick_r;
        end else begin : g_lead
            assign etick_s = tick_r;
        end
    endgenerate

    // Key decode, neighbour cell candidate and blocking check.
    always_comb begin
        key_valid_s = 1'b0;
        key_dir_s   = 2'd0;
        cur_col_s   = cell_of(x_r);
        cur_row_s   = cell_of(y_r);
        cand_col_s  = cur_col_s;
        cand_row_s  = cur_row_s;
        off_grid_s  = 1'b0;
        case (keycode)
            8'h1A:   begin key_valid_s = 1'b1; key_dir_s = 2'd0; end
            8'h16:   begin key_valid_s = 1'b1; key_dir_s = 2'd1; end
            8'h04:   begin key_valid_s = 1'b1; key_dir_s = 2'd2; end
            8'h07:   begin key_valid_s = 1'b1; key_dir_s = 2'd3; end
            default: begin key_valid_s = 1'b0; key_dir_s = 2'd0; end
        endcase
        case (key_dir_s)
            2'd0: begin
                if (cur_row_s == 5'd0) off_grid_s = 1'b1;
                else                   cand_row_s = cur_row_s - 5'd1;
            end
            2'd1: begin
                if (cur_row_s >= LAST_ROW) off_grid_s = 1'b1;
                else                       cand_row_s = cur_row_s + 5'd1;
            end
            2'd2: begin
                if (cur_col_s == 5'd0) off_grid_s = 1'b1;
                else                   cand_col_s = cur_col_s - 5'd1;
            end
            2'd3: begin
                if (cur_col_s >= LAST_COL) off_grid_s = 1'b1;
                else                       cand_col_s = cur_col_s + 5'd1;
            end
            default: off_grid_s = 1'b1;
        endcase
        blocked_s = off_grid_s
                  | ((cand_col_s == cell_of(OtherX)) && (cand_row_s == cell_of(OtherY)))
                  | ((cand_col_s == OtherTgtCol) && (cand_row_s == OtherTgtRow));
    end

    // One STEP along the active axis and arrival test against the destination cell.
    always_comb begin
        step_x_s = x_r;
        step_y_s = y_r;
        if (state_r == ST_IDLE) begin
            move_dir_s = key_dir_s;
            dest_col_s = cand_col_s;
            dest_row_s = cand_row_s;
        end else begin
            move_dir_s = dir_r;
            dest_col_s = tcol_r;
            dest_row_s = trow_r;
        end
        case (move_dir_s)
            2'd0:    step_y_s = y_r - STEP_V;
            2'd1:    step_y_s = y_r + STEP_V;
            2'd2:    step_x_s = x_r - STEP_V;
            2'd3:    step_x_s = x_r + STEP_V;
            default: begin step_x_s = x_r; step_y_s = y_r; end
        endcase
        arrive_s = (step_x_s == {dest_col_s, 5'd0}) && (step_y_s == {dest_row_s, 5'd0});
    end

    // Next-state logic: everything advances only on the effective tick.
    always_comb begin
        state_n = state_r;
        x_n     = x_r;
        y_n     = y_r;
        tcol_n  = tcol_r;
        trow_n  = trow_r;
        dir_n   = dir_r;
        if (etick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (key_valid_s) begin
                        dir_n = key_dir_s;
                        if (!blocked_s) begin
                            tcol_n  = cand_col_s;
                            trow_n  = cand_row_s;
                            x_n     = step_x_s;
                            y_n     = step_y_s;
                            state_n = arrive_s ? ST_IDLE : ST_MOVE;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_MOVE: begin
                    x_n = step_x_s;
                    y_n = step_y_s;
                    if (arrive_s) state_n = ST_IDLE;
                    else          state_n = ST_MOVE;
                end
                default: state_n = ST_IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State, position, claim, facing and Moving registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            x_r      <= START_X;
            y_r      <= START_Y;
            tcol_r   <= START_X[9:5];
            trow_r   <= START_Y[9:5];
            dir_r    <= 2'd0;
            moving_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            x_r      <= x_n;
            y_r      <= y_n;
            tcol_r   <= tcol_n;
            trow_r   <= trow_n;
            dir_r    <= dir_n;
            moving_r <= (state_n == ST_MOVE);
        end
    end

    assign TankX  = x_r;
    assign TankY  = y_r;
    assign TgtCol = tcol_r;
    assign TgtRow = trow_r;
    assign Dir    = dir_r;
    assign Moving = moving_r;

endmodule

// File: tb/tb_tank_motion.sv
// Directed bench for tank_motion: several instances with different start
// cells exercise single moves, wall and tank blocking, tie-breaking between
// two cross-connected tanks, key changes mid-move and reset mid-move.
module tb_tank_motion;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: starts at (0,0), free playfield.
    logic [7:0] key_a;
    logic [9:0] ax, ay;
    logic [4:0] acol, arow;
    logic [1:0] adir;
    logic       amov;
    // Instance B: starts at the far corner (608,448).
    logic [7:0] key_b;
    logic [9:0] bx, by;
    logic [4:0] bcol, brow;
    logic [1:0] bdir;
    logic       bmov;
    // Instance C: starts at (64,64) with bench-driven other-tank inputs.
    logic [7:0] key_c;
    logic [9:0] c_ox, c_oy;
    logic [4:0] c_ocol, c_orow;
    logic [9:0] cx, cy;
    logic [4:0] ccol, crow;
    logic [1:0] cdir;
    logic       cmov;
    // Cross-connected pair: P1 (YIELD 0) at cell (1,2), P2 (YIELD 1) at cell (3,2).
    logic [7:0] key_p1, key_p2;
    logic [9:0] p1x, p1y, p2x, p2y;
    logic [4:0] p1col, p1row, p2col, p2row;
    logic [1:0] p1dir, p2dir;
    logic       p1mov, p2mov;

    tank_motion #(.START_X(10'd0), .START_Y(10'd0), .STEP(2), .YIELD(0)) u_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(key_a),
        .OtherX(10'd608), .OtherY(10'd448), .OtherTgtCol(5'd19), .OtherTgtRow(5'd14),
        .TankX(ax), .TankY(ay), .TgtCol(acol), .TgtRow(arow), .Dir(adir), .Moving(amov));

    tank_motion #(.START_X(10'd608), .START_Y(10'd448), .STEP(2), .YIELD(0)) u_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(key_b),
        .OtherX(10'd0), .OtherY(10'd0), .OtherTgtCol(5'd0), .OtherTgtRow(5'd0),
        .TankX(bx), .TankY(by), .TgtCol(bcol), .TgtRow(brow), .Dir(bdir), .Moving(bmov));

    tank_motion #(.START_X(10'd64), .START_Y(10'd64), .STEP(2), .YIELD(0)) u_c (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(key_c),
        .OtherX(c_ox), .OtherY(c_oy), .OtherTgtCol(c_ocol), .OtherTgtRow(c_orow),
        .TankX(cx), .TankY(cy), .TgtCol(ccol), .TgtRow(crow), .Dir(cdir), .Moving(cmov));

    tank_motion #(.START_X(10'd32), .START_Y(10'd64), .STEP(2), .YIELD(0)) u_p1 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(key_p1),
        .OtherX(p2x), .OtherY(p2y), .OtherTgtCol(p2col), .OtherTgtRow(p2row),
        .TankX(p1x), .TankY(p1y), .TgtCol(p1col), .TgtRow(p1row), .Dir(p1dir), .Moving(p1mov));

    tank_motion #(.START_X(10'd96), .START_Y(10'd64), .STEP(2), .YIELD(1)) u_p2 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(key_p2),
        .OtherX(p1x), .OtherY(p1y), .OtherTgtCol(p1col), .OtherTgtRow(p1row),
        .TankX(p2x), .TankY(p2y), .TgtCol(p2col), .TgtRow(p2row), .Dir(p2dir), .Moving(p2mov));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame pulse; returns on a falling Clk edge well after both eticks.
    task automatic do_frame();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0;
        key_a = 8'h00; key_b = 8'h00; key_c = 8'h00; key_p1 = 8'h00; key_p2 = 8'h00;
        c_ox = 10'd96; c_oy = 10'd64; c_ocol = 5'd19; c_orow = 5'd14;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Reset state.
        chk("rst_ax", 16'(ax), 16'd0);
        chk("rst_ay", 16'(ay), 16'd0);
        chk("rst_acol", 16'(acol), 16'd0);
        chk("rst_amov", 16'(amov), 16'd0);
        chk("rst_adir", 16'(adir), 16'd0);
        chk("rst_bx", 16'(bx), 16'd608);
        chk("rst_brow", 16'(brow), 16'd14);

        // Walls: A up at row 0, B right at column 19; C blocked by the other tank's body.
        key_a = 8'h1A; key_b = 8'h07; key_c = 8'h07;
        do_frame();
        chk("wall_a_dir", 16'(adir), 16'd0);
        chk("wall_a_y", 16'(ay), 16'd0);
        chk("wall_a_mov", 16'(amov), 16'd0);
        chk("wall_b_x", 16'(bx), 16'd608);
        chk("wall_b_dir", 16'(bdir), 16'd3);
        chk("wall_b_mov", 16'(bmov), 16'd0);
        chk("body_c_x", 16'(cx), 16'd64);
        chk("body_c_dir", 16'(cdir), 16'd3);
        chk("body_c_mov", 16'(cmov), 16'd0);

        // C blocked by the other tank's claim only.
        c_ox = 10'd320; c_oy = 10'd320; c_ocol = 5'd3; c_orow = 5'd2;
        do_frame();
        chk("claim_c_x", 16'(cx), 16'd64);
        chk("claim_c_mov", 16'(cmov), 16'd0);
        chk("claim_c_col", 16'(ccol), 16'd2);

        // Single move right on A: 16 frames of 2 pixels.
        key_a = 8'h07; key_b = 8'h00; key_c = 8'h00;
        do_frame();
        chk("mv_first_col", 16'(acol), 16'd1);
        chk("mv_first_dir", 16'(adir), 16'd3);
        chk("mv_first_x", 16'(ax), 16'd2);
        chk("mv_first_mov", 16'(amov), 16'd1);
        for (int i = 2; i <= 16; i++) begin
            do_frame();
            chk("mv_x", 16'(ax), 16'(2 * i));
            chk("mv_mov", 16'(amov), (i < 16) ? 16'd1 : 16'd0);
        end
        chk("mv_end_col", 16'(acol), 16'd1);
        chk("mv_end_y", 16'(ay), 16'd0);

        // Same-frame conflict for cell (2,2): P1 wins, P2 yields.
        key_a = 8'h00; key_p1 = 8'h07; key_p2 = 8'h04;
        do_frame();
        chk("tie_p1_col", 16'(p1col), 16'd2);
        chk("tie_p1_x", 16'(p1x), 16'd34);
        chk("tie_p1_mov", 16'(p1mov), 16'd1);
        chk("tie_p2_x", 16'(p2x), 16'd96);
        chk("tie_p2_col", 16'(p2col), 16'd3);
        chk("tie_p2_dir", 16'(p2dir), 16'd2);
        chk("tie_p2_mov", 16'(p2mov), 16'd0);
        key_p1 = 8'h00; key_p2 = 8'h00;

        // Key change ignored mid-move: A moves down from (0,0), key turns left after 3 frames.
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        key_a = 8'h16;
        repeat (3) do_frame();
        chk("ign_y3", 16'(ay), 16'd6);
        key_a = 8'h04;
        repeat (13) do_frame();
        chk("ign_y", 16'(ay), 16'd32);
        chk("ign_x", 16'(ax), 16'd0);
        chk("ign_dir", 16'(adir), 16'd1);
        chk("ign_mov", 16'(amov), 16'd0);
        chk("ign_row", 16'(arow), 16'd1);

        // Reset mid-move: A moves right from (0,32), reset after 5 frames.
        key_a = 8'h07;
        repeat (5) do_frame();
        chk("rm_x5", 16'(ax), 16'd10);
        chk("rm_mov5", 16'(amov), 16'd1);
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        chk("rm_x", 16'(ax), 16'd0);
        chk("rm_y", 16'(ay), 16'd0);
        chk("rm_mov", 16'(amov), 16'd0);
        chk("rm_col", 16'(acol), 16'd0);
        chk("rm_row", 16'(arow), 16'd0);
        chk("rm_dir", 16'(adir), 16'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
